// File: rtl/a_sram_pkg.sv
// Shared constants, FSM state type and word-slicing helper for the A-operand
// matrix loader. Optional feature macro: A_SRAM_PARITY_EN (spare-byte parity).
package a_sram_pkg;

    localparam int MATRIX_SIZE = 64;
    localparam int LANE_NUM    = 16;
    localparam int WORD_BYTES  = 32;
    localparam int DATA_W      = WORD_BYTES * 8;
    localparam int WORD_W      = 264;
    localparam int DEPTH       = MATRIX_SIZE * MATRIX_SIZE / (LANE_NUM * WORD_BYTES);
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int MATRIX_W    = MATRIX_SIZE * MATRIX_SIZE * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Half-row (addr even: cols 0..31, odd: cols 32..63) of row
    // (addr/2)*LANE_NUM + lane, lowest column placed in the MSB byte.
    function automatic logic [WORD_W-1:0] build_word(
        input logic [MATRIX_W-1:0] m,
        input int                  lane,
        input logic [ADDR_W-1:0]   addr
    );
        logic [WORD_W-1:0] w;
        int row;
        int col0;
        w    = '0;
        row  = int'(addr >> 1) * LANE_NUM + lane;
        col0 = int'(addr[0]) * WORD_BYTES;
        for (int k = 0; k < WORD_BYTES; k++) begin
            w[8*k +: 8] = m[(row*MATRIX_SIZE + col0 + WORD_BYTES - 1 - k)*8 +: 8];
        end
`ifdef A_SRAM_PARITY_EN
        // One parity bit per 4-byte group of the data field.
        for (int g = 0; g < 8; g++) begin
            w[DATA_W + g] = ^w[32*g +: 32];
        end
`endif
        return w;
    endfunction

endpackage

// File: rtl/a_sram_bank.sv
// One DEPTH x WORD_W bank: synchronous write port plus registered read port.
// A read and write to the same address in one cycle returns the old word.
module a_sram_bank
    import a_sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage array; never cleared so a reset keeps any words already loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; holds its value while re is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/a_sram_matrix_loader.sv
// A-operand writer plus 16-bank A-buffer: slices a 64x64 byte matrix into
// half-row words, writes all lanes in parallel, then streams the banks out.
// Optional feature macro: A_SRAM_PARITY_EN (parity in the spare byte).
//
// state | meaning
// IDLE  | waiting for start
// WRITE | one word per lane written each cycle, addr 0..DEPTH-1
// DONE  | one-cycle done pulse, then back to IDLE
module a_sram_matrix_loader
    import a_sram_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MATRIX_W-1:0]        matrix,
    output logic                       busy,
    output logic                       done,
    output logic                       write_en,
    output logic [ADDR_W-1:0]          write_addr,
    input  logic                       output_en,
    output logic [LANE_NUM*WORD_W-1:0] data_out,
    output logic                       out_valid
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] rd_ptr;

    // FSM state and write address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    // Next-state and write-address sequencing; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (addr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = DONE;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    assign write_en   = (state == WRITE);
    assign busy       = (state == WRITE);
    assign done       = (state == DONE);
    assign write_addr = addr;

    // Read pointer and valid flag; pointer wraps back to 0 after DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= output_en;
            if (output_en) begin
                rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    for (genvar lane = 0; lane < LANE_NUM; lane++) begin : g_lane
        logic [WORD_W-1:0] wdata;

        assign wdata = build_word(matrix, lane, addr);

        a_sram_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (write_en),
            .waddr (addr),
            .wdata (wdata),
            .re    (output_en),
            .raddr (rd_ptr),
            .rdata (data_out[lane*WORD_W +: WORD_W])
        );
    end

endmodule

// File: tb/tb_a_sram_matrix_loader.sv
// Directed bench for a_sram_matrix_loader: load, read-stream with wrap,
// ignored start during WRITE, and reset in the middle of a load.
module tb_a_sram_matrix_loader;

    localparam int MS    = 64;
    localparam int LN    = 16;
    localparam int WW    = 264;
    localparam int MW    = MS * MS * 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [MW-1:0]     matrix;
    logic              busy;
    logic              done;
    logic              write_en;
    logic [2:0]        write_addr;
    logic              output_en;
    logic [LN*WW-1:0]  data_out;
    logic              out_valid;

    logic [MW-1:0]     mat_a;
    logic [MW-1:0]     mat_b;
    logic [255:0]      hand_data;
    int                n_cmp  = 0;
    int                n_fail = 0;

    a_sram_matrix_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix     (matrix),
        .busy       (busy),
        .done       (done),
        .write_en   (write_en),
        .write_addr (write_addr),
        .output_en  (output_en),
        .data_out   (data_out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] spare_of(input logic [255:0] d);
        logic [7:0] s;
        s = 8'h00;
`ifdef A_SRAM_PARITY_EN
        for (int g = 0; g < 8; g++) s[g] = ^d[32*g +: 32];
`endif
        return s;
    endfunction

    function automatic logic [WW-1:0] exp_word(input logic [MW-1:0] m, input int lane, input int a);
        logic [255:0] d;
        int r;
        int c0;
        r  = (a / 2) * LN + lane;
        c0 = (a % 2) * 32;
        for (int k = 0; k < 32; k++) d[8*k +: 8] = m[(r*MS + c0 + 31 - k)*8 +: 8];
        return {spare_of(d), d};
    endfunction

    function automatic logic [WW-1:0] lane_of(input logic [LN*WW-1:0] v, input int lane);
        return v[lane*WW +: WW];
    endfunction

    initial begin
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                mat_a[(i*MS + j)*8 +: 8] = 8'((i + j) % 256);
                mat_b[(i*MS + j)*8 +: 8] = 8'((3*i + j + 7) % 256);
            end
        end

        rst       = 1'b1;
        start     = 1'b0;
        output_en = 1'b0;
        matrix    = mat_a;
        step();
        rst = 1'b0;
        check("rst_busy",      WW'(busy),       '0);
        check("rst_done",      WW'(done),       '0);
        check("rst_write_en",  WW'(write_en),   '0);
        check("rst_addr",      WW'(write_addr), '0);
        check("rst_out_valid", WW'(out_valid),  '0);
        for (int l = 0; l < LN; l++) check($sformatf("rst_data_l%0d", l), lane_of(data_out, l), '0);

        // Load A; a second start pulse during WRITE must be ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ld_we_%0d", i),   WW'(write_en),   WW'(1));
            check($sformatf("ld_busy_%0d", i), WW'(busy),       WW'(1));
            check($sformatf("ld_addr_%0d", i), WW'(write_addr), WW'(i));
            check($sformatf("ld_done_%0d", i), WW'(done),       '0);
            start = (i == 2);
            step();
        end
        start = 1'b0;
        check("ld_done_pulse", WW'(done),     WW'(1));
        check("ld_done_we",    WW'(write_en), '0);
        check("ld_done_busy",  WW'(busy),     '0);
        step();
        check("post_done",     WW'(done),     '0);
        check("post_busy",     WW'(busy),     '0);
        check("post_we",       WW'(write_en), '0);
        step();
        check("idle_we",       WW'(write_en), '0);

        // Stream 10 words: addr 0..7 then wrap to 0, 1.
        output_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("rd_valid_%0d", c), WW'(out_valid), WW'(1));
            for (int l = 0; l < LN; l++)
                check($sformatf("rd_c%0d_l%0d", c, l), lane_of(data_out, l), exp_word(mat_a, l, c % 8));
            if (c == 0) begin
                hand_data = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
                check("hand_b0_a0", lane_of(data_out, 0), {spare_of(hand_data), hand_data});
`ifdef A_SRAM_PARITY_EN
                check("hand_b0_a0_p0", WW'(data_out[256]), WW'(^32'h1C1D1E1F));
`else
                check("hand_b0_a0_spare", WW'(data_out[263:256]), '0);
`endif
            end
            if (c == 1) begin
                hand_data = 256'h2122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F40;
                check("hand_b1_a1", lane_of(data_out, 1), {spare_of(hand_data), hand_data});
            end
            if (c == 7) begin
                hand_data = 256'h5F606162636465666768696A6B6C6D6E6F707172737475767778797A7B7C7D7E;
                check("hand_b15_a7", lane_of(data_out, 15), {spare_of(hand_data), hand_data});
            end
        end
        output_en = 1'b0;
        step();
        check("rd_off_valid", WW'(out_valid), '0);
        for (int l = 0; l < LN; l++)
            check($sformatf("rd_hold_l%0d", l), lane_of(data_out, l), exp_word(mat_a, l, 1));

        // Load B and reset during the 4th write (addr 3).
        matrix = mat_b;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ab_addr_%0d", i), WW'(write_addr), WW'(i));
            step();
        end
        check("ab_addr_3", WW'(write_addr), WW'(3));
        check("ab_we_3",   WW'(write_en),   WW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ab_we",     WW'(write_en),   '0);
        check("ab_busy",   WW'(busy),       '0);
        check("ab_done",   WW'(done),       '0);
        check("ab_addr",   WW'(write_addr), '0);
        check("ab_valid",  WW'(out_valid),  '0);
        check("ab_data_l0", lane_of(data_out, 0), '0);
        step();
        check("ab_idle_we", WW'(write_en), '0);

        // Addrs 0..3 now hold B, 4..7 still hold A; read pointer restarts at 0.
        output_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("ab_rd_valid_%0d", c), WW'(out_valid), WW'(1));
            for (int l = 0; l < LN; l++)
                check($sformatf("ab_rd_c%0d_l%0d", c, l), lane_of(data_out, l),
                      (c < 4) ? exp_word(mat_b, l, c) : exp_word(mat_a, l, c));
        end
        output_en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/a_sram_matrix_loader.md
Name: a_sram_matrix_loader

Overview:
Loads a 64x64 byte matrix into 16 parallel SRAM banks (lanes), then streams the banks back out. The writer slices the matrix into 32-byte half-rows and interleaves rows across lanes. The block combines the A-operand writer and the 16-bank A-buffer. It sits between the matrix source and the systolic/MAC array input of the accelerator.

Parameters:
MATRIX_SIZE, 64, matrix rows = cols, in bytes.
LANE_NUM, 16, number of banks/lanes.
WORD_BYTES, 32, data bytes per bank word (half-row).
WORD_W, 264, bank word width; [255:0] data, [263:256] spare.
DEPTH, MATRIX_SIZE*MATRIX_SIZE/(LANE_NUM*WORD_BYTES) = 8, words per bank (derived).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load from IDLE.
matrix  in  MATRIX_SIZE*MATRIX_SIZE*8  flat matrix; element (r,c) at bits [(r*MATRIX_SIZE+c)*8 +: 8]; must be held stable during the load.
busy  out  1  high while writing.
done  out  1  one-cycle pulse after the last write.
write_en  out  1  high in each cycle a word is written to all banks.
write_addr  out  log2(DEPTH)  bank address being written.
output_en  in  1  read-stream enable.
data_out  out  LANE_NUM*WORD_W  lane L at [L*WORD_W +: WORD_W].
out_valid  out  1  data_out holds a freshly read word.

Behaviour:
- Reset: FSM=IDLE; busy, done, write_en, write_addr, out_valid, data_out, read pointer all 0. Bank contents are not cleared.
- FSM states:
  - IDLE: on start=1, go to WRITE with addr=0.
  - WRITE: write_en=1 and busy=1 for exactly DEPTH consecutive cycles, addr 0..DEPTH-1. After addr DEPTH-1 is written, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. First write occurs in the cycle after start is sampled.
- Word mapping for lane L, addr a:
  - row = (a/2)*LANE_NUM + L; col0 = (a%2)*WORD_BYTES.
  - word[8k+7:8k] = matrix[row][col0+31-k] for k=0..31, so column col0 is in the MSB byte.
  - word[263:256] = 0 (see optional feature).
- All LANE_NUM banks are written in the same cycle at the same addr. Each bank is DEPTH x WORD_W, named mem[addr] inside bank L.
- Read:
  - While output_en=1, each cycle data_out <= mem[rd_ptr] of every lane, out_valid <= 1, rd_ptr <= rd_ptr+1, wrapping DEPTH-1 -> 0.
  - output_en=0: out_valid <= 0, data_out and rd_ptr hold.
- Simultaneous read and write to the same addr returns the old data (read-before-write).
- rst asserted mid-load aborts the load. Banks keep any partially written words; FSM returns to IDLE.

Optional Feature:
A_SRAM_PARITY_EN:
- Defined: word[256+g] = XOR of data bytes 4g..4g+3 (bits [32g+31:32g]) for g=0..7. The spare byte is written with each word and read back unchanged.
- Undefined: spare byte written as 0.

Decomposition:
- Shared package a_sram_pkg holds MATRIX_SIZE, LANE_NUM, WORD_BYTES, WORD_W, DEPTH, the ADDR_W localparam, and the FSM state enum (IDLE/WRITE/DONE).
- One sub-module, a_sram_bank: single DEPTH x WORD_W synchronous bank (write port + registered read port), instantiated LANE_NUM times.
- Writer FSM and slicing logic live in the top module.

Test Plan:
- Matrix m[i][j]=(i+j)%256, rst 1 cycle, start pulse -> write_en high exactly 8 cycles with addrs 0..7, done pulse in the following cycle, busy low afterwards.
- After load, check bank 0 addr 0 = {8'h00, 256'h000102...1E1F}; bank 1 addr 1 = data bytes 0x21..0x40 (MSB to LSB); bank 15 addr 7 = bytes 0x5F..0x7E.
- Check all 16 banks x 8 addrs against the mapping formula -> 0 mismatches.
- output_en high 10 cycles -> out_valid from cycle 1; data_out streams addr 0..7, then 0, 1 (wrap); output_en low -> out_valid 0 and data held.
- start pulsed again during WRITE -> ignored; still exactly 8 writes. rst at 4th write -> FSM IDLE, write_en 0 next cycle, addrs 0..3 retain data.
- With A_SRAM_PARITY_EN, bank 0 addr 0 spare byte = XOR-group parity of bytes 00..1F, e.g. bit 256 = ^32'h1C1D1E1F; without the macro the spare byte is 8'h00.
